// File: rtl/mod_envelope.sv
// ADSR envelope generator that produces an unsigned 18.14 attenuation factor (0..ONE).
// It advances one stage step per sample tick, and o_valid follows each tick by one cycle.
module mod_envelope #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 14
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic             i_gate,
  input  logic [WIDTH-1:0] i_attack_step,
  input  logic [WIDTH-1:0] i_decay_step,
  input  logic [WIDTH-1:0] i_sustain_level,
  input  logic [WIDTH-1:0] i_release_step,
  output logic [WIDTH-1:0] o_envelope,
  output logic             o_valid,
  output logic [2:0]       o_stage
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;

  // Sustain targets above unity are pinned to unity so the level never exceeds ONE
  function automatic logic [WIDTH-1:0] clamp_one(input logic [WIDTH-1:0] val);
    clamp_one = (val > ONE) ? ONE : val;
  endfunction

  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic [WIDTH-1:0] level_r;
  logic [WIDTH-1:0] level_nxt_s;
  logic             valid_r;
  logic [WIDTH-1:0] sustain_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   dec_diff_s;
  logic [WIDTH:0]   rel_diff_s;
  logic             attack_done_s;
  logic             decay_done_s;
  logic             release_done_s;

  // The extra top bit catches both add overflow and subtract underflow
  assign sustain_s      = clamp_one(i_sustain_level);
  assign sum_s          = {1'b0, level_r} + {1'b0, i_attack_step};
  assign dec_diff_s     = {1'b0, level_r} - {1'b0, i_decay_step};
  assign rel_diff_s     = {1'b0, level_r} - {1'b0, i_release_step};
  assign attack_done_s  = (i_attack_step == ZERO) || (sum_s >= {1'b0, ONE});
  assign decay_done_s   = (i_decay_step == ZERO) || dec_diff_s[WIDTH] ||
                          (dec_diff_s <= {1'b0, sustain_s});
  assign release_done_s = (i_release_step == ZERO) || rel_diff_s[WIDTH] ||
                          (rel_diff_s == {(WIDTH+1){1'b0}});

  // State, level and valid registers; state and level move only on a tick
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      level_r <= ZERO;
      valid_r <= 1'b0;
    end else begin
      valid_r <= i_tick;
      if (i_tick) begin
        state_r <= state_nxt_s;
        level_r <= level_nxt_s;
      end
    end
  end

  // Next-state selection: the gate check wins over the level step
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:    state_nxt_s = i_gate ? ST_ATTACK : ST_IDLE;
      ST_ATTACK:  begin
        if (!i_gate)            state_nxt_s = ST_RELEASE;
        else if (attack_done_s) state_nxt_s = ST_DECAY;
        else                    state_nxt_s = ST_ATTACK;
      end
      ST_DECAY:   begin
        if (!i_gate)           state_nxt_s = ST_RELEASE;
        else if (decay_done_s) state_nxt_s = ST_SUSTAIN;
        else                   state_nxt_s = ST_DECAY;
      end
      ST_SUSTAIN: state_nxt_s = i_gate ? ST_SUSTAIN : ST_RELEASE;
      ST_RELEASE: begin
        if (i_gate)              state_nxt_s = ST_ATTACK;
        else if (release_done_s) state_nxt_s = ST_IDLE;
        else                     state_nxt_s = ST_RELEASE;
      end
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // Level update; a stage change caused by the gate leaves the level untouched
  always_comb begin
    level_nxt_s = level_r;
    case (state_r)
      ST_IDLE:    level_nxt_s = ZERO;
      ST_ATTACK:  begin
        if (!i_gate)            level_nxt_s = level_r;
        else if (attack_done_s) level_nxt_s = ONE;
        else                    level_nxt_s = sum_s[WIDTH-1:0];
      end
      ST_DECAY:   begin
        if (!i_gate)           level_nxt_s = level_r;
        else if (decay_done_s) level_nxt_s = sustain_s;
        else                   level_nxt_s = dec_diff_s[WIDTH-1:0];
      end
      ST_SUSTAIN: level_nxt_s = i_gate ? sustain_s : level_r;
      ST_RELEASE: begin
        if (i_gate)              level_nxt_s = level_r;
        else if (release_done_s) level_nxt_s = ZERO;
        else                     level_nxt_s = rel_diff_s[WIDTH-1:0];
      end
      default:    level_nxt_s = ZERO;
    endcase
  end

  assign o_envelope = level_r;
  assign o_stage    = state_r;
  assign o_valid    = valid_r;

endmodule
